// File: rtl/npc_seq.sv
// npc_seq: next-PC sequencer and fetch controller with imem req/ack handshake and sticky fault halt
module npc_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, instr_n, br_off, npc;
  logic [CW-1:0] wait_cnt, wait_n;
  logic [1:0] code_n;
  assign imem_req    = state == FETCH;
  assign instr_valid = state == EXEC;
  assign err         = state == HALT;
  assign imem_addr   = pc;
  assign pc_4        = pc + 32'd4;
  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign npc = npc_sel == 2'b00 ? pc_4 :
               npc_sel == 2'b01 ? (br_taken ? pc_4 + br_off : pc_4) :
               npc_sel == 2'b10 ? {pc_4[31:28], instr[25:0], 2'b00} : rs_data;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    wait_n  = wait_cnt;
    code_n  = err_code;
    case (state)
      FETCH: begin
        wait_n = imem_ack ? '0 : wait_cnt + 1'b1;
        if (imem_ack) begin
          instr_n = imem_rdata;
          state_n = EXEC;
        end else if (wait_cnt == LAST) begin
          state_n = HALT;
          code_n  = 2'b01;
        end
      end
      EXEC: begin
        // A misaligned jr target faults before the PC is touched.
        if (commit && npc_sel == 2'b11 && rs_data[1:0] != 2'b00) begin
          state_n = HALT;
          code_n  = 2'b10;
        end else if (commit) begin
          pc_n    = npc;
          state_n = FETCH;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr    <= '0;
      wait_cnt <= '0;
      err_code <= 2'b00;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      instr    <= instr_n;
      wait_cnt <= wait_n;
      err_code <= code_n;
    end
  end
endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: directed-vector bench for npc_seq with hand-computed expectations
module tb_npc_seq;
  logic        clk = 0, reset = 0, imem_ack = 0, br_taken = 0, commit = 0;
  logic [31:0] imem_rdata = 0, rs_data = 0;
  logic [1:0]  npc_sel = 0;
  logic        imem_req, instr_valid, err;
  logic [31:0] imem_addr, instr, pc, pc_4;
  logic [1:0]  err_code;
  int          n_vec = 0, n_bad = 0;

  npc_seq #(.RESET_PC(32'h0000_3000), .WAIT_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_4(pc_4), .npc_sel(npc_sel),
    .br_taken(br_taken), .rs_data(rs_data), .commit(commit), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ack = 1;
    imem_rdata = w;
    step();
    imem_ack = 0;
  endtask

  task automatic retire(input logic [1:0] sel, input logic bt, input logic [31:0] rs);
    npc_sel = sel;
    br_taken = bt;
    rs_data = rs;
    commit = 1;
    step();
    commit = 0;
  endtask

  initial begin
    step();
    do_reset();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_err", {err, err_code}, 0);
    // commit is ignored while fetching
    commit = 1;
    step();
    commit = 0;
    chk("fetch_commit_ign", {imem_req, imem_addr}, {1'b1, 32'h0000_3000});
    fetch(32'h2408_0005);
    chk("ex_valid", instr_valid, 1);
    chk("ex_instr", instr, 32'h2408_0005);
    chk("ex_pc4", pc_4, 32'h0000_3004);
    chk("ex_req", imem_req, 0);
    // late ack during EXEC must not disturb the latched word
    imem_ack = 1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 0;
    chk("ex_ack_ign", instr, 32'h2408_0005);
    for (int i = 0; i < 20; i++) step();
    chk("stall_hold", {instr_valid, pc}, {1'b1, 32'h0000_3000});
    retire(2'b00, 0, 0);
    chk("seq_addr", imem_addr, 32'h0000_3004);
    chk("seq_req", {imem_req, instr_valid}, 2'b10);
    fetch(32'h0);
    retire(2'b11, 0, 32'h0000_3010);
    chk("jr_3010", imem_addr, 32'h0000_3010);
    fetch(32'h1000_FFFD);
    retire(2'b01, 1, 0);
    chk("br_taken", pc, 32'h0000_3008);
    fetch(32'h0);
    retire(2'b11, 0, 32'h0000_3010);
    fetch(32'h1000_FFFD);
    retire(2'b01, 0, 0);
    chk("br_not_taken", pc, 32'h0000_3014);
    fetch(32'h0);
    retire(2'b11, 0, 32'h0FFF_FFFC);
    fetch(32'h0C00_0010);
    chk("j_pc4", pc_4, 32'h1000_0000);
    retire(2'b10, 0, 0);
    chk("j_target", pc, 32'h1000_0040);
    fetch(32'h0);
    retire(2'b11, 0, 32'h0000_3100);
    chk("jr_3100", imem_addr, 32'h0000_3100);
    fetch(32'h0);
    retire(2'b11, 0, 32'h0000_3102);
    chk("jr_mis_err", {err, err_code}, {1'b1, 2'b10});
    chk("jr_mis_req", {imem_req, instr_valid}, 2'b00);
    chk("jr_mis_pc", pc, 32'h0000_3100);
    do_reset();
    chk("rst2_pc", pc, 32'h0000_3000);
    chk("rst2_err", {err, err_code}, 0);
    // timeout: 16 FETCH cycles with req high, then HALT
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_req%0d", i), imem_req, 1);
      step();
    end
    chk("to_err", {err, err_code}, {1'b1, 2'b01});
    chk("to_req_off", {imem_req, instr_valid}, 2'b00);
    imem_ack = 1;
    imem_rdata = 32'h1234_5678;
    commit = 1;
    step();
    imem_ack = 0;
    commit = 0;
    chk("halt_ign", {err, err_code, imem_req, instr_valid}, {1'b1, 2'b01, 2'b00});
    chk("halt_instr", instr, 0);
    do_reset();
    fetch(32'hABCD_0123);
    retire(2'b00, 0, 0);
    fetch(32'hABCD_0124);
    chk("pre_rst_pc", pc, 32'h0000_3004);
    reset = 1;
    commit = 1;
    step();
    reset = 0;
    commit = 0;
    chk("rst_exec_pc", pc, 32'h0000_3000);
    chk("rst_exec_st", {imem_req, instr_valid, err}, 3'b100);
    chk("rst_exec_instr", instr, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
